fake_tdc_multi: RTL and testbench
=================================

// Module: fake_tdc_multi
// PURPOSE
//  Parametrised synthetic TDC event source for bring-up of the FIFO/readout path without real hits.
//  Generates events periodically or on an external trigger. Each event is a burst of NUM_CH timestamp words.
//  Each word is presented to the FIFO writer with wr_en held until f_FIFO_writing_done.
//  Events that cannot be accepted are dropped and counted. Sits where the real TDC front-end feeds the FIFO writer.
// PARAMETERS
//  NUM_CH     4      channels per event (1..16); words per burst
//  DATA_W     24     timestamp word width (3 bytes)
//  CNT_W      30     period counter width
//  CH_STEP    5      timestamp offset added per channel index (synthetic skew)
//  OVR_W      16     overrun counter width
// PORTS
//  clk                 in   1        system clock
//  rst                 in   1        synchronous, active-high reset
//  enable              in   1        1 = generator armed
//  mode                in   1        0 = periodic, 1 = triggered
//  period              in   CNT_W    cycles between periodic events; values <2 treated as 2
//  trig                in   1        event request pulse (mode=1 only)
//  f_FIFO_writing_done in   1        FIFO writer has consumed current word
//  wr_en               out  1        word valid / write request (registered)
//  data                out  DATA_W   synthetic timestamp, stable while wr_en=1
//  ch_id               out  clog2(NUM_CH) (min 1)  channel index of data
//  busy                out  1        burst in progress (state WRITE or GAP)
//  overrun_cnt         out  OVR_W    dropped events, saturating
// BEHAVIOUR
//  Reset: state=IDLE; ts, period cnt, overrun_cnt=0; wr_en=0, data=0, ch_id=0, busy=0. Reset at any point, incl. mid-burst, clears all of these at that edge.
//  ts: free-running DATA_W counter, +1 every cycle after reset, wraps 2^DATA_W-1 -> 0.
//  Period counter (mode=0, enable=1): counts 0..P-1, where P = max(period,2).
//   - tick when cnt==P-1; cnt returns to 0.
//   - runs in all non-IDLE states; held at 0 in IDLE.
//   - period change takes effect at next wrap.
//  Event request: mode=0 -> tick; mode=1 -> trig=1 (period counter ignored).
//  States:
//   IDLE  -> DELAY when enable=1. Stays IDLE while enable=0.
//   DELAY -> WRITE on event request.
//            - Latch base=ts (value in request cycle) and ch=0.
//            - wr_en=1 from next cycle; data=base+0*CH_STEP mod 2^DATA_W.
//            -> IDLE if enable=0 and no request this cycle.
//   WRITE: wr_en=1, data/ch_id held.
//            - On f_FIFO_writing_done=1: wr_en=0 next cycle.
//            - If ch<NUM_CH-1 -> GAP; else -> DELAY (or IDLE if enable=0).
//   GAP: exactly 1 cycle, wr_en=0.
//            - ch+=1, data=base+ch*CH_STEP.
//            -> WRITE (wr_en=1 next cycle).
//  Word spacing: done in cycle n -> wr_en low n+1 (GAP) -> next word wr_en high n+2.
//  All words of one event carry the same base; only offsets differ.
//  enable=0 mid-burst: current burst completes all NUM_CH words, then IDLE.
//  mode change is sampled only in DELAY.
//  Overrun: an event request while state is WRITE or GAP is dropped.
//   - overrun_cnt+=1, saturating at 2^OVR_W-1.
//   - Current burst is unaffected.
//   - A request in the same cycle the last word completes (WRITE->DELAY) also counts as overrun; it does not start a burst.
//  f_FIFO_writing_done while wr_en=0 is ignored.
//  busy=1 iff state is WRITE or GAP.
// TESTING
//  1. rst high 3 cycles mid-burst -> next cycle: wr_en=0, data=0, ch_id=0, overrun_cnt=0, busy=0.
//  2. mode=0, period=10, NUM_CH=4, done 1 cycle after each wr_en rise
//     -> 4 words/event, data=base, base+5, +10, +15; ch_id 0..3; events 10 cycles apart; overrun_cnt=0.
//  3. mode=0, period=10, done withheld 25 cycles on first word -> overrun_cnt=2; burst completes all 4 words.
//  4. period=0 and period=1 -> behaves as period=2 (event request every 2 cycles).
//  5. mode=1, trig pulse in DELAY -> wr_en high 1 cycle later with data=ts at trig.
//     trig during WRITE -> overrun_cnt+1, no extra burst.
//  6. Force ts near 2^24-1 (base=0xFFFFFE) -> data=0xFFFFFE, 0x000003, 0x000008, 0x00000D.
//     enable=0 after word 1 -> remaining words sent, then IDLE, no further wr_en.

Source files
------------

// File: rtl/fake_tdc_multi.sv
// Synthetic TDC event source: periodic or triggered bursts
// of NUM_CH timestamp words into the FIFO writer handshake.
module fake_tdc_multi #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 24,
  parameter int CNT_W   = 30,
  parameter int CH_STEP = 5,
  parameter int OVR_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [CNT_W-1:0]  period,
  input  logic              trig,
  input  logic              f_FIFO_writing_done,
  output logic              wr_en,
  output logic [DATA_W-1:0] data,
  output logic [CH_W-1:0]   ch_id,
  output logic              busy,
  output logic [OVR_W-1:0]  overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    WRITE,
    GAP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] ts_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  p_lat;
  logic [CNT_W-1:0]  p_eff;
  logic              mode_q;
  logic              mode_eff;
  logic              tick;
  logic              req;
  logic              last;
  logic              in_burst;

  assign p_eff = (period < CNT_W'(2)) ? CNT_W'(2) : period;

  assign tick = (state_q != IDLE)
             && (cnt_q == p_lat - CNT_W'(1));

  // mode is only re-sampled while waiting for an event
  assign mode_eff = (state_q == DELAY) ? mode : mode_q;
  assign req      = mode_eff ? trig : tick;

  assign last     = (ch_id == CH_W'(NUM_CH - 1));
  assign in_burst = (state_q == WRITE)
                 || (state_q == GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = DELAY;
      end
      DELAY: begin
        if (req)          state_d = WRITE;
        else if (!enable) state_d = IDLE;
      end
      WRITE: begin
        if (f_FIFO_writing_done) begin
          if (!last)      state_d = GAP;
          else if (enable) state_d = DELAY;
          else            state_d = IDLE;
        end
      end
      GAP: begin
        state_d = WRITE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = in_burst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      cnt_q       <= '0;
      p_lat       <= CNT_W'(2);
      mode_q      <= 1'b0;
      wr_en       <= 1'b0;
      data        <= '0;
      ch_id       <= '0;
      overrun_cnt <= '0;
    end else begin
      ts_q <= ts_q + DATA_W'(1);

      // new period only picked up on a wrap
      if (state_q == IDLE || tick) begin
        cnt_q <= '0;
        p_lat <= p_eff;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_q == IDLE || state_q == DELAY) begin
        mode_q <= mode;
      end

      wr_en <= (state_d == WRITE);

      if (state_q == DELAY && req) begin
        data  <= ts_q;
        ch_id <= '0;
      end else if (state_q == GAP) begin
        data  <= data + DATA_W'(CH_STEP);
        ch_id <= ch_id + CH_W'(1);
      end

      if (in_burst && req && overrun_cnt != '1) begin
        overrun_cnt <= overrun_cnt + OVR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fake_tdc_multi.sv
// Directed bench for fake_tdc_multi: reset, periodic,
// overrun, short period, trigger and timestamp wrap.
module tb_fake_tdc_multi;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 24;
  localparam int CNT_W   = 30;
  localparam int CH_STEP = 5;
  localparam int OVR_W   = 16;

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              enable = 1'b0;
  logic              mode   = 1'b0;
  logic              trig   = 1'b0;
  logic              done   = 1'b0;
  logic [CNT_W-1:0]  period = CNT_W'(10);
  logic              wr_en;
  logic              busy;
  logic [DATA_W-1:0] data;
  logic [1:0]        ch_id;
  logic [OVR_W-1:0]  overrun_cnt;
  logic [DATA_W-1:0] ts_m;

  int n_cmp = 0;
  int n_bad = 0;

  fake_tdc_multi #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .CH_STEP(CH_STEP),
    .OVR_W  (OVR_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .mode               (mode),
    .period             (period),
    .trig               (trig),
    .f_FIFO_writing_done(done),
    .wr_en              (wr_en),
    .data               (data),
    .ch_id              (ch_id),
    .busy               (busy),
    .overrun_cnt        (overrun_cnt)
  );

  always #5 clk = ~clk;

  // reference timestamp: cycles since last reset edge
  always @(posedge clk) begin
    ts_m <= rst ? '0 : ts_m + DATA_W'(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int lim,
                         output bit ok,
                         output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n <= lim) begin
      if (wr_en === 1'b1) ok = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  task automatic ack();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    mode   = 1'b0;
    trig   = 1'b0;
    done   = 1'b0;
    period = CNT_W'(10);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    do_reset();
    enable = 1'b1;
    for (int w = 0; w < 3; w++) begin
      wait_wr(20, ok, n);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rst_pre_wr: wr_en %b required 1",
                 wr_en);
      end
      if (w < 2) ack();
    end
    repeat (15) step();
    n_cmp++;
    if (ch_id !== 2'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_state: ch %0d busy %b req 2 1",
               ch_id, busy);
    end
    n_cmp++;
    if (overrun_cnt !== OVR_W'(1)) begin
      n_bad++;
      $display("FAIL rst_pre_ovr: got %0d required 1",
               overrun_cnt);
    end
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wr_en: got %b required 0", wr_en);
    end
    n_cmp++;
    if (data !== '0) begin
      n_bad++;
      $display("FAIL rst_data: got %0h required 0", data);
    end
    n_cmp++;
    if (ch_id !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_ch_id: got %0d required 0", ch_id);
    end
    n_cmp++;
    if (overrun_cnt !== '0) begin
      n_bad++;
      $display("FAIL rst_ovr: got %0d required 0",
               overrun_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy: got %b required 0", busy);
    end
    rst    = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_periodic();
    bit ok;
    int n;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] prev;
    base = '0;
    prev = '0;
    do_reset();
    enable = 1'b1;
    for (int ev = 0; ev < 3; ev++) begin
      for (int w = 0; w < NUM_CH; w++) begin
        wait_wr(15, ok, n);
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL per_timeout: ev %0d w %0d", ev, w);
        end
        if (w == 0) begin
          if (ev > 0) begin
            n_cmp++;
            if (ts_m - prev !== DATA_W'(10)) begin
              n_bad++;
              $display("FAIL per_spacing: got %0d req 10",
                       ts_m - prev);
            end
          end
          prev = ts_m;
          base = ts_m - DATA_W'(1);
        end
        n_cmp++;
        if (data !== base + DATA_W'(w * CH_STEP)) begin
          n_bad++;
          $display("FAIL per_data: got %0h required %0h",
                   data, base + DATA_W'(w * CH_STEP));
        end
        n_cmp++;
        if (ch_id !== 2'(w)) begin
          n_bad++;
          $display("FAIL per_ch_id: got %0d required %0d",
                   ch_id, w);
        end
        ack();
      end
    end
    n_cmp++;
    if (overrun_cnt !== '0) begin
      n_bad++;
      $display("FAIL per_ovr: got %0d required 0",
               overrun_cnt);
    end
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    bit ok;
    int n;
    logic [DATA_W-1:0] base;
    do_reset();
    enable = 1'b1;
    wait_wr(15, ok, n);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ovr_first: wr_en %b required 1", wr_en);
    end
    base = ts_m - DATA_W'(1);
    repeat (21) step();
    n_cmp++;
    if (wr_en !== 1'b1 || data !== base) begin
      n_bad++;
      $display("FAIL ovr_hold: wr %b data %0h req 1 %0h",
               wr_en, data, base);
    end
    ack();
    for (int w = 1; w < NUM_CH; w++) begin
      wait_wr(5, ok, n);
      n_cmp++;
      if (!ok || data !== base + DATA_W'(w * CH_STEP)) begin
        n_bad++;
        $display("FAIL ovr_word: w %0d got %0h required %0h",
                 w, data, base + DATA_W'(w * CH_STEP));
      end
      n_cmp++;
      if (ch_id !== 2'(w)) begin
        n_bad++;
        $display("FAIL ovr_ch_id: got %0d required %0d",
                 ch_id, w);
      end
      ack();
    end
    n_cmp++;
    if (overrun_cnt !== OVR_W'(2)) begin
      n_bad++;
      $display("FAIL ovr_cnt: got %0d required 2",
               overrun_cnt);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_busy: got %b required 0", busy);
    end
    wait_wr(5, ok, n);
    n_cmp++;
    if (!ok || n != 2) begin
      n_bad++;
      $display("FAIL ovr_next: ok %b wait %0d required 2",
               ok, n);
    end
    n_cmp++;
    if (overrun_cnt !== OVR_W'(2)) begin
      n_bad++;
      $display("FAIL ovr_after: got %0d required 2",
               overrun_cnt);
    end
    enable = 1'b0;
  endtask

  task automatic test_small_period();
    bit ok;
    int n;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      period = CNT_W'(p);
      enable = 1'b1;
      wait_wr(10, ok, n);
      n_cmp++;
      if (!ok || n != 3) begin
        n_bad++;
        $display("FAIL sp_latency: p %0d got %0d req 3",
                 p, n);
      end
      for (int w = 0; w < NUM_CH; w++) begin
        if (w > 0) wait_wr(5, ok, n);
        ack();
      end
      n_cmp++;
      if (overrun_cnt !== OVR_W'(3)) begin
        n_bad++;
        $display("FAIL sp_ovr: p %0d got %0d required 3",
                 p, overrun_cnt);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL sp_busy: got %b required 0", busy);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_trigger();
    bit ok;
    int n;
    int rises;
    logic [DATA_W-1:0] t;
    do_reset();
    mode   = 1'b1;
    enable = 1'b1;
    repeat (4) step();
    t    = ts_m;
    trig = 1'b1;
    step();
    trig = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL trg_rise: got %b required 1", wr_en);
    end
    n_cmp++;
    if (data !== t) begin
      n_bad++;
      $display("FAIL trg_base: got %0h required %0h",
               data, t);
    end
    trig = 1'b1;
    step();
    trig = 1'b0;
    n_cmp++;
    if (overrun_cnt !== OVR_W'(1) || wr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL trg_ovr: ovr %0d wr %b required 1 1",
               overrun_cnt, wr_en);
    end
    for (int w = 0; w < NUM_CH; w++) begin
      wait_wr(5, ok, n);
      n_cmp++;
      if (!ok || data !== t + DATA_W'(w * CH_STEP)) begin
        n_bad++;
        $display("FAIL trg_word: w %0d got %0h required %0h",
                 w, data, t + DATA_W'(w * CH_STEP));
      end
      ack();
    end
    rises = 0;
    repeat (10) begin
      step();
      if (wr_en === 1'b1) rises++;
    end
    n_cmp++;
    if (rises != 0) begin
      n_bad++;
      $display("FAIL trg_extra: got %0d words required 0",
               rises);
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    int n;
    int rises;
    logic [DATA_W-1:0] exp_w [NUM_CH];
    exp_w = '{24'hFFFFFE, 24'h000003,
              24'h000008, 24'h00000D};
    do_reset();
    mode   = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    force dut.ts_q = 24'hFFFFFE;
    trig = 1'b1;
    step();
    trig = 1'b0;
    release dut.ts_q;
    for (int w = 0; w < NUM_CH; w++) begin
      wait_wr(5, ok, n);
      n_cmp++;
      if (!ok || data !== exp_w[w]) begin
        n_bad++;
        $display("FAIL wrap_data: w %0d got %0h required %0h",
                 w, data, exp_w[w]);
      end
      n_cmp++;
      if (ch_id !== 2'(w)) begin
        n_bad++;
        $display("FAIL wrap_ch_id: got %0d required %0d",
                 ch_id, w);
      end
      ack();
      if (w == 0) enable = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_busy: got %b required 0", busy);
    end
    rises = 0;
    repeat (10) begin
      step();
      if (wr_en === 1'b1) rises++;
    end
    n_cmp++;
    if (rises != 0) begin
      n_bad++;
      $display("FAIL wrap_idle: got %0d words required 0",
               rises);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_overrun();
    test_small_period();
    test_trigger();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
